// File: rtl/updatefc_scheduler.sv
// UpdateFC DLLP scheduler for one VC: tracks pending P/NP/Cpl updates from credit
// releases and a refresh timer, round-robins them onto a 32-bit valid/ready DLLP port.
module updatefc_scheduler #(
    parameter int TIMER_PERIOD = 30,
    parameter int TIMER_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_init_done,
    input  logic [2:0]  vc_id,
    input  logic [1:0]  hdr_scale,
    input  logic [1:0]  data_scale,
    input  logic [7:0]  p_hdr_fc,
    input  logic [11:0] p_data_fc,
    input  logic [7:0]  np_hdr_fc,
    input  logic [11:0] np_data_fc,
    input  logic [7:0]  cpl_hdr_fc,
    input  logic [11:0] cpl_data_fc,
    input  logic [2:0]  credit_rel,
    output logic        dllp_valid,
    input  logic        dllp_ready,
    output logic [31:0] dllp_data,
    output logic [2:0]  pending
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         rr;
    logic [1:0]         sel;
    logic [1:0]         pick;
    logic               tick;
    logic               hs;
    logic [2:0]         set_v;
    logic [2:0]         clr_v;
    logic [7:0]         hdr_mux;
    logic [11:0]        data_mux;
    logic [2:0]         type_code;

    assign tick  = fc_init_done && (timer == TIMER_W'(TIMER_PERIOD - 1));
    assign hs    = dllp_valid && dllp_ready;
    assign set_v = credit_rel | {3{tick}};
    assign clr_v = hs ? (3'b001 << sel) : 3'b000;

    // First pending type at or after the round-robin pointer, wrapping P->NP->Cpl->P.
    always_comb begin
        pick = rr;
        case (rr)
            2'd0:    pick = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);
            2'd1:    pick = pending[1] ? 2'd1 : (pending[2] ? 2'd2 : 2'd0);
            default: pick = pending[2] ? 2'd2 : (pending[0] ? 2'd0 : 2'd1);
        endcase
    end

    always_comb begin
        hdr_mux   = p_hdr_fc;
        data_mux  = p_data_fc;
        type_code = 3'b100;
        case (pick)
            2'd1: begin
                hdr_mux   = np_hdr_fc;
                data_mux  = np_data_fc;
                type_code = 3'b101;
            end
            2'd2: begin
                hdr_mux   = cpl_hdr_fc;
                data_mux  = cpl_data_fc;
                type_code = 3'b110;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!fc_init_done || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // A set arriving in the same cycle as the handshake clear keeps the bit high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (!fc_init_done) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_v) | set_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dllp_valid <= 1'b0;
            dllp_data  <= '0;
            rr         <= 2'd0;
            sel        <= 2'd0;
        end else if (!fc_init_done) begin
            state      <= IDLE;
            dllp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        sel        <= pick;
                        dllp_data  <= {type_code, 1'b0, vc_id, hdr_scale, data_scale,
                                       hdr_mux, 1'b0, data_mux};
                        dllp_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (dllp_ready) begin
                        dllp_valid <= 1'b0;
                        rr         <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dllp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updatefc_scheduler.sv
// Scoreboard bench for updatefc_scheduler: stimulus pushes expected words, a negedge
// monitor pops and compares on every handshake and checks bubble/hold behaviour.
module tb_updatefc_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fc_init_done;
    logic [2:0]  vc_id;
    logic [1:0]  hdr_scale, data_scale;
    logic [7:0]  p_hdr_fc, np_hdr_fc, cpl_hdr_fc;
    logic [11:0] p_data_fc, np_data_fc, cpl_data_fc;
    logic [2:0]  credit_rel;
    logic        dllp_valid;
    logic        dllp_ready;
    logic [31:0] dllp_data;
    logic [2:0]  pending;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    updatefc_scheduler #(.TIMER_PERIOD(30), .TIMER_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .fc_init_done(fc_init_done), .vc_id(vc_id),
        .hdr_scale(hdr_scale), .data_scale(data_scale),
        .p_hdr_fc(p_hdr_fc), .p_data_fc(p_data_fc),
        .np_hdr_fc(np_hdr_fc), .np_data_fc(np_data_fc),
        .cpl_hdr_fc(cpl_hdr_fc), .cpl_data_fc(cpl_data_fc),
        .credit_rel(credit_rel), .dllp_valid(dllp_valid), .dllp_ready(dllp_ready),
        .dllp_data(dllp_data), .pending(pending)
    );

    function automatic logic [31:0] mkword(input logic [2:0] t, input logic [2:0] vc,
                                           input logic [1:0] hsc, input logic [1:0] dsc,
                                           input logic [7:0] h, input logic [11:0] d);
        return {t, 1'b0, vc, hsc, dsc, h, 1'b0, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: handshakes are sampled on the falling edge, completing at the next rise.
    initial begin
        logic        prev_hs, prev_hold;
        logic [31:0] prev_data, exp;
        prev_hs = 1'b0; prev_hold = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hs = 1'b0; prev_hold = 1'b0;
            end else begin
                if (prev_hs) chk("bubble_after_word", {31'd0, dllp_valid}, 32'd0);
                if (prev_hold && dllp_valid) chk("data_hold", dllp_data, prev_data);
                if (dllp_valid && dllp_ready) begin
                    if (sb.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_word: got %h, expected none", dllp_data);
                    end else begin
                        exp = sb.pop_front();
                        chk("word", dllp_data, exp);
                    end
                end
                prev_hs   = dllp_valid && dllp_ready;
                prev_hold = dllp_valid && !dllp_ready;
                prev_data = dllp_data;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic restart();
        rst_n = 1'b0; fc_init_done = 1'b0; credit_rel = 3'b000; dllp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse(input logic [2:0] rel);
        credit_rel = rel;
        step();
        credit_rel = 3'b000;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 10 && !dllp_valid; i++) step();
        chk(name, {31'd0, dllp_valid}, 32'd1);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin
        int t1, t2, n;
        logic [2:0] prevp;
        vc_id = 3'd0; hdr_scale = 2'd0; data_scale = 2'd0;
        p_hdr_fc = 8'h20; p_data_fc = 12'h080;
        np_hdr_fc = 8'h11; np_data_fc = 12'h222;
        cpl_hdr_fc = 8'h33; cpl_data_fc = 12'h444;
        rst_n = 1'b0; fc_init_done = 1'b0; credit_rel = '0; dllp_ready = 1'b1;
        #2;
        chk("reset_valid", {31'd0, dllp_valid}, 32'd0);
        chk("reset_data", dllp_data, 32'd0);
        chk("reset_pending", {29'd0, pending}, 32'd0);

        // 1) single P update
        restart();
        sb.push_back(32'h8004_0080);
        fc_init_done = 1'b1;
        pulse(3'b001);
        wait_empty("t1_drain");
        step();
        chk("t1_pending", {29'd0, pending}, 32'd0);

        // 2) all three released together: P, NP, Cpl in order
        restart();
        vc_id = 3'd5; hdr_scale = 2'd2; data_scale = 2'd1;
        sb.push_back(mkword(3'b100, 3'd5, 2'd2, 2'd1, 8'h20, 12'h080));
        sb.push_back(mkword(3'b101, 3'd5, 2'd2, 2'd1, 8'h11, 12'h222));
        sb.push_back(mkword(3'b110, 3'd5, 2'd2, 2'd1, 8'h33, 12'h444));
        fc_init_done = 1'b1;
        pulse(3'b111);
        wait_empty("t2_drain");

        // 3) periodic refresh bursts every 30 cycles
        restart();
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mkword(3'b100, 3'd5, 2'd2, 2'd1, 8'h20, 12'h080));
            sb.push_back(mkword(3'b101, 3'd5, 2'd2, 2'd1, 8'h11, 12'h222));
            sb.push_back(mkword(3'b110, 3'd5, 2'd2, 2'd1, 8'h33, 12'h444));
        end
        fc_init_done = 1'b1;
        t1 = -1; t2 = -1; prevp = 3'b000;
        for (n = 1; n <= 70; n++) begin
            step();
            if (pending == 3'b111 && prevp != 3'b111) begin
                if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n;
            end
            prevp = pending;
        end
        chk("t3_first_tick", t1, 32'd30);
        chk("t3_period", t2 - t1, 32'd30);
        chk("t3_drained", sb.size(), 32'd0);

        // 4) stalled SEND while credits change: word keeps sampled hdr_fc
        restart();
        p_hdr_fc = 8'h20;
        dllp_ready = 1'b0;
        fc_init_done = 1'b1;
        pulse(3'b001);
        wait_valid("t4_valid");
        sb.push_back(mkword(3'b100, 3'd5, 2'd2, 2'd1, 8'h20, 12'h080));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) p_hdr_fc = 8'h21;
            step();
        end
        chk("t4_hold", dllp_data, mkword(3'b100, 3'd5, 2'd2, 2'd1, 8'h20, 12'h080));
        dllp_ready = 1'b1;
        wait_empty("t4_drain");

        // 5) release coinciding with the P handshake re-arms P with fresh credits
        restart();
        p_hdr_fc = 8'h20;
        dllp_ready = 1'b0;
        fc_init_done = 1'b1;
        pulse(3'b001);
        wait_valid("t5_valid");
        sb.push_back(mkword(3'b100, 3'd5, 2'd2, 2'd1, 8'h20, 12'h080));
        sb.push_back(mkword(3'b100, 3'd5, 2'd2, 2'd1, 8'h30, 12'h080));
        p_hdr_fc = 8'h30; dllp_ready = 1'b1;
        pulse(3'b001);
        chk("t5_pending_kept", {29'd0, pending}, 32'd1);
        chk("t5_bubble", {31'd0, dllp_valid}, 32'd0);
        wait_empty("t5_drain");
        step();
        chk("t5_pending_clear", {29'd0, pending}, 32'd0);

        // 6) fc_init_done dropped mid-SEND with NP and Cpl pending
        restart();
        dllp_ready = 1'b0;
        fc_init_done = 1'b1;
        pulse(3'b110);
        wait_valid("t6_valid");
        chk("t6_pending_before", {29'd0, pending}, 32'd6);
        chk("t6_np_word", dllp_data, mkword(3'b101, 3'd5, 2'd2, 2'd1, 8'h11, 12'h222));
        fc_init_done = 1'b0;
        step();
        chk("t6_valid_drop", {31'd0, dllp_valid}, 32'd0);
        chk("t6_pending_drop", {29'd0, pending}, 32'd0);
        dllp_ready = 1'b1;
        pulse(3'b111);
        repeat (4) step();
        chk("t6_rel_ignored", {29'd0, pending}, 32'd0);
        fc_init_done = 1'b1;
        repeat (20) step();
        chk("t6_quiet_after_enable", {29'd0, pending}, 32'd0);

        // async reset while a word is being offered
        restart();
        dllp_ready = 1'b0;
        fc_init_done = 1'b1;
        pulse(3'b001);
        wait_valid("t7_valid");
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_valid", {31'd0, dllp_valid}, 32'd0);
        chk("t7_async_pending", {29'd0, pending}, 32'd0);
        restart();
        repeat (3) step();
        chk("final_queue", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
